// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the burst master.
// Contents: burst and response encodings, the default AxCACHE value and the
// burst-master FSM state type.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // Normal non-cacheable bufferable.
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StDone
    } state_e;

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master.
// Accepts one command (address, beats-1, log2 beat bytes, direction), runs the
// matching AXI read or write burst, streams write data in / read data out and
// reports one completion status pulse per command.
//
// Ports:
//   aclk_i, areset_ni         clock, synchronous active-low reset
//   cmd_*                     command handshake and fields
//   wr_*                      write-data input stream (passes through to W)
//   rd_*                      read-data output stream (passes through from R)
//   done_valid_o/done_resp_o  one-cycle completion pulse and AXI-coded status
//   aw_*, w_*, b_*, ar_*, r_* AXI4 master channels
//
// Build option: define AXI_BMASTER_4K_CHECK_EN to reject commands that cross
// a 4 KB page (completed with DECERR and no bus activity).
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned LEN_BITS  = 8,
    parameter int unsigned SIZE_BITS = 3
) (
    input  logic                   aclk_i,
    input  logic                   areset_ni,

    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_write_i,
    input  logic [ADDR_BITS-1:0]   cmd_addr_i,
    input  logic [LEN_BITS-1:0]    cmd_len_i,
    input  logic [SIZE_BITS-1:0]   cmd_size_i,

    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [DATA_BITS-1:0]   wr_data_i,
    input  logic [DATA_BITS/8-1:0] wr_strb_i,

    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [DATA_BITS-1:0]   rd_data_o,
    output logic                   rd_last_o,

    output logic                   done_valid_o,
    output logic [1:0]             done_resp_o,

    output logic                   aw_valid_o,
    input  logic                   aw_ready_i,
    output logic [ADDR_BITS-1:0]   aw_addr_o,
    output logic [LEN_BITS-1:0]    aw_len_o,
    output logic [SIZE_BITS-1:0]   aw_size_o,
    output logic [1:0]             aw_burst_o,
    output logic [3:0]             aw_cache_o,

    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    output logic [DATA_BITS-1:0]   w_data_o,
    output logic [DATA_BITS/8-1:0] w_strb_o,
    output logic                   w_last_o,

    input  logic                   b_valid_i,
    output logic                   b_ready_o,
    input  logic [1:0]             b_resp_i,

    output logic                   ar_valid_o,
    input  logic                   ar_ready_i,
    output logic [ADDR_BITS-1:0]   ar_addr_o,
    output logic [LEN_BITS-1:0]    ar_len_o,
    output logic [SIZE_BITS-1:0]   ar_size_o,
    output logic [1:0]             ar_burst_o,
    output logic [3:0]             ar_cache_o,

    input  logic                   r_valid_i,
    output logic                   r_ready_o,
    input  logic [DATA_BITS-1:0]   r_data_i,
    input  logic [1:0]             r_resp_i,
    input  logic                   r_last_i
);

    localparam int unsigned StrbBits = DATA_BITS / 8;
    // Largest legal AxSIZE for this data width.
    localparam logic [SIZE_BITS-1:0] SizeMax = SIZE_BITS'($clog2(StrbBits));

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [SIZE_BITS-1:0] size_q, size_d;
    // One bit wider than len so a 2^LEN_BITS-beat burst never wraps.
    logic [LEN_BITS:0]    cnt_q, cnt_d;
    logic [1:0]           resp_q, resp_d;

    logic [LEN_BITS:0]    len_ext;
    logic                 cnt_at_len;
    logic                 cross_4k;

    assign len_ext    = {1'b0, len_q};
    assign cnt_at_len = (cnt_q == len_ext);

`ifdef AXI_BMASTER_4K_CHECK_EN
    logic [ADDR_BITS-1:0] cmd_bytes;
    logic [ADDR_BITS-1:0] cmd_last_addr;

    always_comb begin
        cmd_bytes     = (ADDR_BITS'(cmd_len_i) + ADDR_BITS'(1)) << cmd_size_i;
        cmd_last_addr = cmd_addr_i + cmd_bytes - ADDR_BITS'(1);
        cross_4k      = (cmd_last_addr[ADDR_BITS-1:12] != cmd_addr_i[ADDR_BITS-1:12]);
    end
`else
    assign cross_4k = 1'b0;
`endif

    // State register.
    always_ff @(posedge aclk_i) begin
        if (!areset_ni) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    addr_d = cmd_addr_i;
                    len_d  = cmd_len_i;
                    size_d = cmd_size_i;
                    cnt_d  = '0;
                    resp_d = RESP_OKAY;
                    if (cmd_size_i > SizeMax) begin
                        resp_d  = RESP_SLVERR;
                        state_d = StDone;
                    end else if (cross_4k) begin
                        resp_d  = RESP_DECERR;
                        state_d = StDone;
                    end else begin
                        state_d = cmd_write_i ? StWrAddr : StRdAddr;
                    end
                end
            end
            StWrAddr: begin
                if (aw_ready_i) state_d = StWrData;
            end
            StWrData: begin
                if (wr_valid_i && w_ready_i) begin
                    if (cnt_at_len) state_d = StWrResp;
                    else            cnt_d   = cnt_q + (LEN_BITS+1)'(1);
                end
            end
            StWrResp: begin
                if (b_valid_i) begin
                    resp_d  = b_resp_i;
                    state_d = StDone;
                end
            end
            StRdAddr: begin
                if (ar_ready_i) state_d = StRdData;
            end
            StRdData: begin
                if (r_valid_i && rd_ready_i) begin
                    // First non-OKAY response is kept.
                    if (resp_q == RESP_OKAY) resp_d = r_resp_i;
                    // Saturate at len+1: any value other than len at r_last
                    // flags a short or over-long burst.
                    if (cnt_q <= len_ext) cnt_d = cnt_q + (LEN_BITS+1)'(1);
                    if (r_last_i) begin
                        if (!cnt_at_len) resp_d = RESP_SLVERR;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        cmd_ready_o  = 1'b0;
        wr_ready_o   = 1'b0;
        rd_valid_o   = 1'b0;
        rd_last_o    = 1'b0;
        done_valid_o = 1'b0;
        done_resp_o  = RESP_OKAY;
        aw_valid_o   = 1'b0;
        w_valid_o    = 1'b0;
        w_last_o     = 1'b0;
        b_ready_o    = 1'b0;
        ar_valid_o   = 1'b0;
        r_ready_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Held low while reset is asserted.
                cmd_ready_o = areset_ni;
            end
            StWrAddr: begin
                aw_valid_o = 1'b1;
            end
            StWrData: begin
                w_valid_o  = wr_valid_i;
                wr_ready_o = w_ready_i;
                w_last_o   = cnt_at_len;
            end
            StWrResp: begin
                b_ready_o = 1'b1;
            end
            StRdAddr: begin
                ar_valid_o = 1'b1;
            end
            StRdData: begin
                rd_valid_o = r_valid_i;
                r_ready_o  = rd_ready_i;
                rd_last_o  = r_last_i;
            end
            StDone: begin
                done_valid_o = 1'b1;
                done_resp_o  = resp_q;
            end
            default: begin
                cmd_ready_o = 1'b0;
            end
        endcase
    end

    assign rd_data_o  = r_data_i;
    assign w_data_o   = wr_data_i;
    assign w_strb_o   = wr_strb_i;

    assign aw_addr_o  = addr_q;
    assign aw_len_o   = len_q;
    assign aw_size_o  = size_q;
    assign aw_burst_o = BURST_INCR;
    assign aw_cache_o = CACHE_DEFAULT;

    assign ar_addr_o  = addr_q;
    assign ar_len_o   = len_q;
    assign ar_size_o  = size_q;
    assign ar_burst_o = BURST_INCR;
    assign ar_cache_o = CACHE_DEFAULT;

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Parametrised AXI4 burst master for single-outstanding INCR read and write transfers. It turns one command (address, beat count, beat size, direction) into a complete AXI transaction, streams write data in and read data out, and reports one completion status per command. It sits between the local DMA/control logic and the system AXI interconnect, with full AW/W/B/AR/R channels.

## Interface
- ADDR_BITS, 32, address width
- DATA_BITS, 32, data width; power of two, 8..1024
- LEN_BITS, 8, burst length field width (beats-1)
- SIZE_BITS, 3, burst size field width
- aclk  in  1  clock
- areset_n  in  1  reset; synchronous and active-low
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_BITS  start address
- cmd_len  in  LEN_BITS  beats-1
- cmd_size  in  SIZE_BITS  log2(bytes per beat)
- wr_valid / wr_ready  in / out  1 / 1  write-data stream handshake
- wr_data / wr_strb  in  DATA_BITS / DATA_BITS/8  write beat and its byte strobes
- rd_valid / rd_ready  out / in  1 / 1  read-data stream handshake
- rd_data  out  DATA_BITS  read beat
- rd_last  out  1  last read beat
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  completion status (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR)
- aw_*, w_*, b_*, ar_*, r_*: standard AXI4 master ports with the usual direction and width. aw/ar addr, len and size use the parameters; burst is 2 bits; cache is 4 bits; w_strb is DATA_BITS/8; b_ready and r_ready are outputs.

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: cmd_ready=1. On a cmd handshake the block latches the command and moves to WR_ADDR or RD_ADDR.
- Illegal size: if cmd_size > log2(DATA_BITS/8), no bus activity occurs. The block goes straight to DONE with done_resp=10.
- WR_ADDR / RD_ADDR: aw_valid or ar_valid is held high with stable fields until ready is seen, then the block moves to WR_DATA or RD_DATA. Burst is always INCR (01); cache is always 0011.
- WR_DATA:
  - w_valid = wr_valid and wr_ready = w_ready (combinational pass-through).
  - w_data and w_strb pass through from wr_data and wr_strb.
  - A beat counter counts from 0 to the latched len. w_last is high when the counter equals len.
  - After the last beat the block moves to WR_RESP.
- WR_RESP: b_ready=1. On b_valid, b_resp is latched and the block moves to DONE.
- RD_DATA:
  - rd_valid = r_valid and r_ready = rd_ready.
  - rd_data and rd_last pass through from r_data and r_last.
  - Status is sticky: the first non-OKAY r_resp is kept.
  - On the r_last beat the block moves to DONE.
- Beat-count mismatch: if r_last arrives with counter ≠ len, done_resp is forced to 10.
- Extra beats: if the counter reaches len without r_last, extra beats are still drained until r_last and done_resp is forced to 10.
- DONE: done_valid=1 for exactly one cycle, then IDLE.
- Counter width is LEN_BITS+1 so it never wraps, including len = all-ones (256 beats at default).

## Timing
- Reset values: cmd_ready=0 during reset, 1 after. All valid, ready and last outputs are 0. Address, len, size and done_resp outputs are 0. aw/ar_burst=01 and aw/ar_cache=0011 constant.
- Command accepted at edge N: aw_valid or ar_valid is high from cycle N+1.
- First W beat can transfer no earlier than the cycle after the AW handshake. W never leads AW.
- done_valid is asserted the cycle after the B handshake or the final R handshake.
- cmd_ready returns the cycle after done_valid, so back-to-back commands are spaced by at least 4 cycles (write) or 3 cycles (read) plus beats.
- Reset mid-transaction: all valid outputs drop at the next edge and the state returns to IDLE. No done_valid is issued for the aborted command.
- wr_valid or rd_ready held low stalls the bus indefinitely with no state corruption.

## Configuration
- AXI_BMASTER_4K_CHECK_EN defined:
  - A command whose last byte, cmd_addr + (cmd_len+1)<<cmd_size - 1, lies in a different 4 KB page from cmd_addr is rejected.
  - No bus activity occurs; DONE is reached with done_resp=11.
- Undefined: no boundary check; the command is issued as given.

## Structure
- Shared package axi_pkg holds:
  - burst and resp enums (BURST_INCR=01, RESP_OKAY..RESP_DECERR);
  - CACHE_DEFAULT=0011;
  - the state enum typedef.
- Single module; no sub-module. The beat counter and status merge are inline.

## Test plan
- Write len=3, size=2, addr 0x100, slave ready always, b_resp=00 -> 4 W beats, w_last on beat 3 only, done_valid once with done_resp=00.
- Read len=0, addr 0x40, r_resp=10 -> one rd beat with rd_last=1, done_resp=10.
- Read len=7 with beat 2 r_resp=11 and beat 5 r_resp=10 -> done_resp=11 (first error sticky).
- Read len=3 with slave asserting r_last on beat 1 -> DONE after beat 1, done_resp=10.
- With the 4K check enabled: write addr 0xFF8, len=3, size=2 -> no aw_valid, done_resp=11. Same command with the check disabled -> normal burst.
- areset_n low for 1 cycle during WR_DATA beat 2 -> w_valid=0 next cycle, no done_valid, cmd_ready=1 afterwards.
